at16_seq_ctrl: RTL and testbench

- Sequencer for the 16-lane multiply / 3:1 adder-tree / accumulator datapath used in layers L10–L16.
- Walks each output pixel through its input-channel chunks (16 products per chunk) and drives the operand buffer read addresses.
- Aligns the accumulator load pulse and the output-valid strobe to the fixed 3-stage tree pipeline.
- Inserts zero-operand bubbles when operands are not available, and latches the per-layer skip-add mode.

---
 rtl/at16_seq_ctrl_if.sv | 40 ++++
 rtl/at16_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_at16_seq_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/at16_seq_ctrl_if.sv
// Bundle between the at16 sequencer and its datapath/operand buffers.
//
// Operand handshake: src_valid is the buffer's "valid" for the chunk at
// rd_addr; the sequencer is "ready" only while it is walking a job. A chunk
// transfers in exactly the cycle where both hold, and rd_en marks that cycle.
// src_valid may drop at any time; the sequencer then inserts a zero bubble
// (op_gate=0) and re-presents the same rd_addr next cycle.
interface at16_seq_ctrl_if #(
  parameter int CHUNK_W = 8,
  parameter int OUT_W   = 16,
  parameter int ADDR_W  = 12
);
  logic               start;
  logic [CHUNK_W-1:0] cfg_chunks;
  logic [OUT_W-1:0]   cfg_outputs;
  logic [2:0]         cfg_u;
  logic               src_valid;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_en;
  logic               op_gate;
  logic               load_sig;
  logic [2:0]         u_out;
  logic               out_valid;
  logic [OUT_W-1:0]   out_idx;
  logic               busy;
  logic               done;
  logic [1:0]         dbg_state;

  modport master (
    input  start, cfg_chunks, cfg_outputs, cfg_u, src_valid,
    output rd_addr, rd_en, op_gate, load_sig, u_out, out_valid, out_idx,
           busy, done, dbg_state
  );

  modport slave (
    output start, cfg_chunks, cfg_outputs, cfg_u, src_valid,
    input  rd_addr, rd_en, op_gate, load_sig, u_out, out_valid, out_idx,
           busy, done, dbg_state
  );
endinterface

// File: rtl/at16_seq_ctrl.sv
// Sequencer for the 16-lane multiply / 3:1 adder tree / accumulator datapath.
// Walks each output through its input-channel chunks, issues operand buffer
// reads, and carries a tag alongside each issued chunk so that the
// accumulator load and output-valid strobes line up with the tree pipeline.
module at16_seq_ctrl #(
  parameter int PIPE_LAT = 3,
  parameter int CHUNK_W  = 8,
  parameter int OUT_W    = 16,
  parameter int ADDR_W   = 12
) (
  input  logic            clk,
  input  logic            rst,
  at16_seq_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One tag per cycle travels with the operands through the tree stages.
  typedef struct packed {
    logic             v;
    logic             first;
    logic             last;
    logic [OUT_W-1:0] idx;
  } tag_t;

  state_e             state_q, state_d;
  logic [CHUNK_W-1:0] n_chunks_q, n_chunks_d;
  logic [OUT_W-1:0]   n_outputs_q, n_outputs_d;
  logic [CHUNK_W-1:0] chunk_cnt_q, chunk_cnt_d;
  logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [2:0]         u_q, u_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_idx_q, out_idx_d;
  tag_t               pipe_q [PIPE_LAT];
  tag_t               pipe_d [PIPE_LAT];

  logic issue;
  logic chunk_last;
  logic out_last;
  logic pipe_busy;
  tag_t tag_in;

  // Next-state logic: job walk, tag pipe shift and output strobe staging.
  always_comb begin
    state_d     = state_q;
    n_chunks_d  = n_chunks_q;
    n_outputs_d = n_outputs_q;
    chunk_cnt_d = chunk_cnt_q;
    out_cnt_d   = out_cnt_q;
    rd_addr_d   = rd_addr_q;
    u_d         = u_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    issue      = (state_q == RUN) && bus.src_valid;
    chunk_last = (chunk_cnt_q == n_chunks_q - CHUNK_W'(1));
    out_last   = (out_cnt_q == n_outputs_q - OUT_W'(1));

    pipe_busy = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      pipe_busy = pipe_busy | pipe_q[i].v;
    end

    // A non-issued cycle pushes v=0: the gated zero product adds nothing.
    tag_in = '0;
    if (issue) begin
      tag_in.v     = 1'b1;
      tag_in.first = (chunk_cnt_q == '0);
      tag_in.last  = chunk_last;
      tag_in.idx   = out_cnt_q;
    end
    pipe_d[0] = tag_in;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    // The completed sum is visible one cycle after its last partial lands.
    out_valid_d = pipe_q[PIPE_LAT-1].v & pipe_q[PIPE_LAT-1].last;
    out_idx_d   = out_valid_d ? pipe_q[PIPE_LAT-1].idx : '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.cfg_outputs != '0) begin
            n_chunks_d  = (bus.cfg_chunks == '0) ? CHUNK_W'(1) : bus.cfg_chunks;
            n_outputs_d = bus.cfg_outputs;
            u_d         = bus.cfg_u;
            chunk_cnt_d = '0;
            out_cnt_d   = '0;
            rd_addr_d   = '0;
            busy_d      = 1'b1;
            state_d     = RUN;
          end else begin
            // Empty job: acknowledge immediately without ever going busy.
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          if (chunk_last) begin
            chunk_cnt_d = '0;
            out_cnt_d   = out_cnt_q + OUT_W'(1);
            if (out_last) begin
              state_d = DRAIN;
            end
          end else begin
            chunk_cnt_d = chunk_cnt_q + CHUNK_W'(1);
          end
        end
      end
      DRAIN: begin
        // Once no live tag is left in the tree stages, the final out_valid
        // is either on the outputs now or already gone.
        if (!pipe_busy) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any job without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_chunks_q  <= '0;
      n_outputs_q <= '0;
      chunk_cnt_q <= '0;
      out_cnt_q   <= '0;
      rd_addr_q   <= '0;
      u_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      n_chunks_q  <= n_chunks_d;
      n_outputs_q <= n_outputs_d;
      chunk_cnt_q <= chunk_cnt_d;
      out_cnt_q   <= out_cnt_d;
      rd_addr_q   <= rd_addr_d;
      u_q         <= u_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // Output drive: issue strobes follow src_valid directly while running.
  always_comb begin
    bus.rd_addr   = rd_addr_q;
    bus.rd_en     = issue;
    bus.op_gate   = issue;
    bus.load_sig  = pipe_q[PIPE_LAT-1].v & pipe_q[PIPE_LAT-1].first;
    bus.u_out     = u_q;
    bus.out_valid = out_valid_q;
    bus.out_idx   = out_idx_q;
    bus.busy      = busy_q;
    bus.done      = done_q;
    bus.dbg_state = state_q;
  end

endmodule

// File: tb/tb_at16_seq_ctrl.sv
// Bench for at16_seq_ctrl: per-job expected strobe timelines are derived from
// the issue schedule, and a small accumulator driven by the sequencer's own
// strobes checks that every output sums exactly its chunks' operands.
module tb_at16_seq_ctrl;

  localparam int MAXC = 512;

  logic clk;
  logic rst;

  at16_seq_ctrl_if #(.CHUNK_W(8), .OUT_W(16), .ADDR_W(12)) bus ();

  at16_seq_ctrl #(
    .PIPE_LAT(3), .CHUNK_W(8), .OUT_W(16), .ADDR_W(12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] opnd(input logic [11:0] a);
    return (32'(a) * 32'd37 + 32'd11) & 32'hFFFF;
  endfunction

  // Reference datapath: product presented with the operands, three register
  // stages, then the accumulator (load replaces, otherwise adds).
  logic [31:0] prod_now, s1, s2, s3, acc;
  assign prod_now = bus.op_gate ? opnd(bus.rd_addr) : 32'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 0; s2 <= 0; s3 <= 0; acc <= 0;
    end else begin
      s1  <= prod_now;
      s2  <= s1;
      s3  <= s2;
      acc <= bus.load_sig ? s3 : acc + s3;
    end
  end

  // Scoreboard of expected per-output sums, in output order.
  logic [31:0] exp_q[$];

  bit e_rden [MAXC];
  int e_addr [MAXC];
  bit e_load [MAXC];
  bit e_ov   [MAXC];
  int e_idx  [MAXC];
  bit sv     [MAXC];
  logic [2:0] prev_u;

  // mode 0: src_valid always high, 1: low in cycles 2-3, 2: random
  task automatic run_job(input int chunks, input int outputs, input logic [2:0] u, input int mode);
    int nch, k_tot, k, last_c, done_c, exp_u;
    logic [31:0] sum;
    nch   = (chunks == 0) ? 1 : chunks;
    k_tot = nch * outputs;
    for (int c = 0; c < MAXC; c++) begin
      e_rden[c] = 0; e_addr[c] = 0; e_load[c] = 0; e_ov[c] = 0; e_idx[c] = 0;
      if (mode == 0)      sv[c] = 1;
      else if (mode == 1) sv[c] = !(c == 2 || c == 3);
      else                sv[c] = (c > 200) || ($urandom_range(0, 3) != 0);
    end
    k = 0; last_c = 0;
    for (int c = 1; c < MAXC - 8 && k < k_tot; c++) begin
      if (sv[c]) begin
        e_rden[c] = 1;
        e_addr[c] = k % 4096;
        if (k % nch == 0) e_load[c+3] = 1;
        if (k % nch == nch - 1) begin
          e_ov[c+4]  = 1;
          e_idx[c+4] = k / nch;
        end
        k++;
        last_c = c;
      end
    end
    done_c = (k_tot == 0) ? 1 : last_c + 5;
    for (int o = 0; o < outputs; o++) begin
      sum = 0;
      for (int ch = 0; ch < nch; ch++) sum += opnd(12'((o * nch + ch) % 4096));
      exp_q.push_back(sum);
    end

    for (int c = 0; c <= done_c + 2; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        bus.start       = 1;
        bus.cfg_chunks  = 8'(chunks);
        bus.cfg_outputs = 16'(outputs);
        bus.cfg_u       = u;
      end else begin
        // Stray starts while the job runs must be ignored.
        bus.start       = (c < done_c) && ($urandom_range(0, 5) == 0);
        bus.cfg_chunks  = 8'($urandom_range(0, 255));
        bus.cfg_outputs = 16'($urandom_range(0, 65535));
        bus.cfg_u       = 3'($urandom_range(0, 7));
      end
      bus.src_valid = sv[c];
      @(negedge clk);
      exp_u = (c >= 1 && k_tot != 0) ? int'(u) : int'(prev_u);
      check("rd_en", 32'(bus.rd_en), 32'(e_rden[c]));
      check("op_gate", 32'(bus.op_gate), 32'(e_rden[c]));
      if (e_rden[c]) check("rd_addr", 32'(bus.rd_addr), 32'(e_addr[c]));
      check("load_sig", 32'(bus.load_sig), 32'(e_load[c]));
      check("out_valid", 32'(bus.out_valid), 32'(e_ov[c]));
      if (e_ov[c]) check("out_idx", 32'(bus.out_idx), 32'(e_idx[c]));
      check("done", 32'(bus.done), 32'(c == done_c));
      check("busy", 32'(bus.busy), 32'(k_tot != 0 && c >= 1 && c < done_c));
      check("u_out", 32'(bus.u_out), 32'(exp_u));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("sb_extra", 32'd1, 32'd0);
        else check("acc_sum", acc, exp_q.pop_front());
      end
    end
    bus.start     = 0;
    bus.src_valid = 0;
    check("sb_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (k_tot != 0) prev_u = u;
  endtask

  initial begin
    rst = 0;
    bus.start = 0; bus.cfg_chunks = 0; bus.cfg_outputs = 0; bus.cfg_u = 0;
    bus.src_valid = 0;
    prev_u = 0;
    #1 rst = 1;
    #2;
    check("rst_rd_en", 32'(bus.rd_en), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_u_out", 32'(bus.u_out), 0);
    check("rst_rd_addr", 32'(bus.rd_addr), 0);
    check("rst_state", 32'(bus.dbg_state), 0);
    @(negedge clk) rst = 0;

    run_job(4, 2, 3'd1, 0);
    run_job(4, 2, 3'd2, 1);
    run_job(0, 3, 3'd0, 0);
    run_job(7, 0, 3'd3, 0);

    // Abort a running job with an asynchronous reset.
    @(posedge clk); #1;
    bus.start = 1; bus.cfg_chunks = 4; bus.cfg_outputs = 2; bus.cfg_u = 6;
    @(posedge clk); #1;
    bus.start = 0; bus.src_valid = 1;
    repeat (4) @(posedge clk);
    #3 rst = 1;
    #1;
    check("abort_rd_en", 32'(bus.rd_en), 0);
    check("abort_op_gate", 32'(bus.op_gate), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_u_out", 32'(bus.u_out), 0);
    check("abort_rd_addr", 32'(bus.rd_addr), 0);
    check("abort_load", 32'(bus.load_sig), 0);
    @(negedge clk) rst = 0;
    prev_u = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 0);
      check("abort_no_valid", 32'(bus.out_valid), 0);
    end
    bus.src_valid = 0;

    run_job(4, 2, 3'd5, 0);
    run_job(3, 2, 3'd4, 2);

    for (int j = 0; j < 20; j++) begin
      run_job($urandom_range(0, 5), $urandom_range(0, 5), 3'($urandom_range(0, 7)), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
